// File: rtl/snapshot_sequencer_pkg.sv
// Shared definitions for the ULA snapshot capture path: FSM encodings and
// the default front-end geometry used by the DOA top.
package snapshot_sequencer_pkg;

   localparam int unsigned ULA_SAMPLE_WIDTH = 12;
   localparam int unsigned ULA_NUM_CH       = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/snapshot_serializer.sv
// Parallel-load holding register for one multi-channel IQ snapshot, emitted
// channel by channel through registered outputs, gated by out_ready.
module snapshot_serializer #(
   parameter int unsigned SAMPLE_WIDTH = 12,
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned CH_WIDTH     = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear,
   input  logic                           load,
   input  logic                           load_last,
   input  logic [NUM_CH*SAMPLE_WIDTH-1:0] in_i,
   input  logic [NUM_CH*SAMPLE_WIDTH-1:0] in_q,
   input  logic                           out_ready,
   output logic [SAMPLE_WIDTH-1:0]        out_i,
   output logic [SAMPLE_WIDTH-1:0]        out_q,
   output logic [CH_WIDTH-1:0]            out_ch,
   output logic                           out_valid,
   output logic                           out_last,
   output logic                           active
);

   localparam logic [CH_WIDTH-1:0] LAST_CH = CH_WIDTH'(NUM_CH - 1);

   logic [SAMPLE_WIDTH-1:0] hold_i [NUM_CH];
   logic [SAMPLE_WIDTH-1:0] hold_q [NUM_CH];
   logic [CH_WIDTH-1:0]     idx;
   logic                    pending;
   logic                    last_snap;

   // pending stays high until the final channel has been handed to the outputs,
   // so a new load is accepted in the same cycle the last word is presented.
   assign active = pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(NUM_CH); k++) begin
            hold_i[k] <= '0;
            hold_q[k] <= '0;
         end
         idx       <= '0;
         pending   <= 1'b0;
         last_snap <= 1'b0;
         out_i     <= '0;
         out_q     <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (clear) begin
         idx       <= '0;
         pending   <= 1'b0;
         last_snap <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (load) begin
         for (int k = 0; k < int'(NUM_CH); k++) begin
            hold_i[k] <= in_i[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            hold_q[k] <= in_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
         end
         last_snap <= load_last;
         pending   <= 1'b1;
         out_last  <= 1'b0;
         // ch0 goes straight to the outputs so it appears the cycle after the load
         if (out_ready) begin
            out_i     <= in_i[SAMPLE_WIDTH-1:0];
            out_q     <= in_q[SAMPLE_WIDTH-1:0];
            out_ch    <= '0;
            out_valid <= 1'b1;
            idx       <= CH_WIDTH'(1);
         end else begin
            out_valid <= 1'b0;
            idx       <= '0;
         end
      end else if (pending && out_ready) begin
         out_i     <= hold_i[idx];
         out_q     <= hold_q[idx];
         out_ch    <= idx;
         out_valid <= 1'b1;
         out_last  <= last_snap && (idx == LAST_CH);
         if (idx == LAST_CH) begin
            pending <= 1'b0;
            idx     <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end else begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: rtl/snapshot_sequencer.sv
// Capture controller for ULA IQ snapshots: start/abort FSM, decimation,
// snapshot counting and overflow reporting in front of the serialiser.
module snapshot_sequencer
   import snapshot_sequencer_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH = ULA_SAMPLE_WIDTH,
   parameter int unsigned NUM_CH       = ULA_NUM_CH,
   parameter int unsigned CH_WIDTH     = 2,
   parameter int unsigned LEN_WIDTH    = 16,
   parameter int unsigned DECIM_WIDTH  = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [LEN_WIDTH-1:0]           cfg_len,
   input  logic [DECIM_WIDTH-1:0]         cfg_decim,
   input  logic                           start,
   input  logic                           abort,
   input  logic [NUM_CH*SAMPLE_WIDTH-1:0] adc_i,
   input  logic [NUM_CH*SAMPLE_WIDTH-1:0] adc_q,
   input  logic                           adc_valid,
   input  logic                           out_ready,
   output logic [SAMPLE_WIDTH-1:0]        out_i,
   output logic [SAMPLE_WIDTH-1:0]        out_q,
   output logic [CH_WIDTH-1:0]            out_ch,
   output logic                           out_valid,
   output logic                           out_last,
   output logic                           busy,
   output logic                           done,
   output logic                           overflow
);

   seq_state_t             state;
   logic [LEN_WIDTH-1:0]   len_q;
   logic [LEN_WIDTH-1:0]   snap_cnt;
   logic [DECIM_WIDTH-1:0] decim_q;
   logic [DECIM_WIDTH-1:0] decim_cnt;
   logic                   slot;
   logic                   final_slot;
   logic                   ser_load;
   logic                   ser_active;

   // A slot is the kept 1-of-(decim+1) adc_valid; it loads only into an idle serialiser.
   assign slot       = (state == ST_RUN) && adc_valid && (decim_cnt == '0);
   assign final_slot = (snap_cnt == len_q - 1'b1);
   assign ser_load   = slot && !ser_active && !abort;

   snapshot_serializer #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .NUM_CH       (NUM_CH),
      .CH_WIDTH     (CH_WIDTH)
   ) u_serializer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (abort),
      .load      (ser_load),
      .load_last (final_slot),
      .in_i      (adc_i),
      .in_q      (adc_q),
      .out_ready (out_ready),
      .out_i     (out_i),
      .out_q     (out_q),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_last  (out_last),
      .active    (ser_active)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         len_q     <= '0;
         decim_q   <= '0;
         snap_cnt  <= '0;
         decim_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
      end else if (abort) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  len_q     <= cfg_len;
                  decim_q   <= cfg_decim;
                  overflow  <= 1'b0;
                  snap_cnt  <= '0;
                  decim_cnt <= '0;
                  busy      <= 1'b1;
                  if (cfg_len != '0) begin
                     state <= ST_RUN;
                  end else begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (adc_valid) begin
                  if (decim_cnt == '0) begin
                     decim_cnt <= decim_q;
                     if (!ser_active) begin
                        snap_cnt <= snap_cnt + 1'b1;
                        if (final_slot) state <= ST_DRAIN;
                     end else begin
                        overflow <= 1'b1;
                     end
                  end else begin
                     decim_cnt <= decim_cnt - 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (out_last) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_snapshot_sequencer.sv
// Scoreboard bench for snapshot_sequencer: expected words are queued as
// snapshots are driven and popped as the serialised stream comes out.
module tb_snapshot_sequencer;

   localparam int unsigned SW  = 12;
   localparam int unsigned NCH = 4;
   localparam int unsigned CW  = 2;
   localparam int unsigned LW  = 16;
   localparam int unsigned DW  = 8;

   typedef struct packed {
      logic [SW-1:0] i;
      logic [SW-1:0] q;
      logic [CW-1:0] ch;
      logic          last;
   } word_t;

   logic              clk;
   logic              rst_n;
   logic [LW-1:0]     cfg_len;
   logic [DW-1:0]     cfg_decim;
   logic              start;
   logic              abort;
   logic [NCH*SW-1:0] adc_i;
   logic [NCH*SW-1:0] adc_q;
   logic              adc_valid;
   logic              out_ready;
   logic [SW-1:0]     out_i;
   logic [SW-1:0]     out_q;
   logic [CW-1:0]     out_ch;
   logic              out_valid;
   logic              out_last;
   logic              busy;
   logic              done;
   logic              overflow;

   word_t exp_q[$];
   word_t got_w;
   word_t want_w;
   int    n_checks   = 0;
   int    n_fail     = 0;
   int    words_seen = 0;
   int    lasts_seen = 0;
   int    done_cnt   = 0;
   int    cyc        = 0;
   int    last_cyc   = 0;
   int    done_cyc   = 0;
   logic  ready_s    = 1'b0;

   snapshot_sequencer #(
      .SAMPLE_WIDTH (SW),
      .NUM_CH       (NCH),
      .CH_WIDTH     (CW),
      .LEN_WIDTH    (LW),
      .DECIM_WIDTH  (DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_len   (cfg_len),
      .cfg_decim (cfg_decim),
      .start     (start),
      .abort     (abort),
      .adc_i     (adc_i),
      .adc_q     (adc_q),
      .adc_valid (adc_valid),
      .out_ready (out_ready),
      .out_i     (out_i),
      .out_q     (out_q),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      ready_s <= out_ready;
   end

   // Stream monitor: every valid word must follow a ready cycle and match the queue head.
   always @(negedge clk) begin
      if (out_valid) begin
         words_seen++;
         n_checks++;
         got_w = '{out_i, out_q, out_ch, out_last};
         if (!ready_s) begin
            n_fail++;
            $display("FAIL valid_without_ready: out_valid=1 at cycle %0d, required out_ready=1 on prior edge", cyc);
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_word: got i=%h q=%h ch=%0d last=%0b, required no word", out_i, out_q, out_ch, out_last);
         end else begin
            want_w = exp_q.pop_front();
            if (got_w !== want_w) begin
               n_fail++;
               $display("FAIL word: got i=%h q=%h ch=%0d last=%0b, required i=%h q=%h ch=%0d last=%0b",
                        got_w.i, got_w.q, got_w.ch, got_w.last, want_w.i, want_w.q, want_w.ch, want_w.last);
            end
         end
         if (out_last) begin
            lasts_seen++;
            last_cyc = cyc;
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   function automatic logic [NCH*SW-1:0] mk_i(input int n);
      logic [NCH*SW-1:0] v;
      for (int c = 0; c < int'(NCH); c++) v[c*SW +: SW] = SW'(32'h100 + n + 32 * c);
      return v;
   endfunction

   function automatic logic [NCH*SW-1:0] mk_q(input int n);
      logic [NCH*SW-1:0] v;
      for (int c = 0; c < int'(NCH); c++) v[c*SW +: SW] = SW'(32'hA05 + 3 * n + 17 * c);
      return v;
   endfunction

   // Drive one adc_valid cycle; if it is expected to be captured, queue its words.
   task automatic adc_sample(input int n, input bit capture, input bit last, input int nwords, input int gap);
      logic [NCH*SW-1:0] vi;
      logic [NCH*SW-1:0] vq;
      vi = mk_i(n);
      vq = mk_q(n);
      adc_i     = vi;
      adc_q     = vq;
      adc_valid = 1'b1;
      if (capture) begin
         for (int c = 0; c < nwords; c++)
            exp_q.push_back('{vi[c*SW +: SW], vq[c*SW +: SW], CW'(c), last && (c == int'(NCH) - 1)});
      end
      @(posedge clk); #1;
      adc_valid = 1'b0;
      repeat (gap - 1) begin
         @(posedge clk); #1;
      end
   endtask

   // Issue a start; cfg is scrambled afterwards since it must not matter mid-capture.
   task automatic pulse_start(input int len, input int decim);
      cfg_len   = LW'(len);
      cfg_decim = DW'(decim);
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      cfg_len   = LW'($urandom);
      cfg_decim = DW'($urandom);
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({out_i, out_q, out_ch, out_valid, out_last, busy, done, overflow} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, required 0", {out_i, out_q, out_ch, out_valid, out_last, busy, done, overflow});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({out_valid, busy, done, overflow} !== 4'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got valid/busy/done/ovf=%b, required 0000", {out_valid, busy, done, overflow});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int bw, bl;
      bit ok;
      bw = words_seen;
      bl = lasts_seen;
      out_ready = 1'b1;
      pulse_start(3, 0);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_busy: got %b, required 1", busy);
      end
      for (int n = 0; n < 3; n++) adc_sample(n, 1'b1, n == 2, NCH, (n == 2) ? 1 : 8);
      wait_done(40, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL basic_done_timeout: got no done, required done within 40 cycles");
      end
      @(negedge clk);
      n_checks++;
      if (done_cyc - last_cyc !== 1) begin
         n_fail++;
         $display("FAIL basic_done_latency: got %0d cycles after last, required 1", done_cyc - last_cyc);
      end
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL basic_after_done: got busy/done=%b, required 00", {busy, done});
      end
      n_checks++;
      if (words_seen - bw !== 12 || lasts_seen - bl !== 1 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL basic_counts: got words=%0d lasts=%0d left=%0d, required 12 1 0", words_seen - bw, lasts_seen - bl, exp_q.size());
      end
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_overflow: got %b, required 0", overflow);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_decimation();
      int bw;
      bit ok;
      bw = words_seen;
      pulse_start(2, 2);
      adc_sample(0, 1'b1, 1'b0, NCH, 6);
      adc_sample(1, 1'b0, 1'b0, NCH, 6);
      adc_sample(2, 1'b0, 1'b0, NCH, 6);
      adc_sample(3, 1'b1, 1'b1, NCH, 1);
      wait_done(40, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL decim_done_timeout: got no done, required done within 40 cycles");
      end
      @(negedge clk);
      n_checks++;
      if (words_seen - bw !== 8 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL decim_counts: got words=%0d left=%0d, required 8 0", words_seen - bw, exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int bw;
      bit ok;
      bw = words_seen;
      out_ready = 1'b1;
      pulse_start(1, 0);
      adc_sample(5, 1'b1, 1'b1, NCH, 1);
      for (int k = 0; k < 6; k++) begin
         out_ready = (k % 2 == 0) ? 1'b0 : 1'b1;
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_done(30, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL bp_done_timeout: got no done, required done within 30 cycles");
      end
      @(negedge clk);
      n_checks++;
      if (words_seen - bw !== 4 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL bp_counts: got words=%0d left=%0d, required 4 0", words_seen - bw, exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow();
      int bw, bl;
      bit ok;
      bw = words_seen;
      bl = lasts_seen;
      out_ready = 1'b1;
      pulse_start(2, 0);
      adc_sample(0, 1'b1, 1'b0, NCH, 2);
      adc_sample(1, 1'b0, 1'b0, NCH, 2);
      adc_sample(2, 1'b1, 1'b1, NCH, 1);
      adc_sample(3, 1'b0, 1'b0, NCH, 1);
      wait_done(30, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL ovf_done_timeout: got no done, required done within 30 cycles");
      end
      @(negedge clk);
      n_checks++;
      if (overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_flag: got %b, required 1", overflow);
      end
      n_checks++;
      if (words_seen - bw !== 8 || lasts_seen - bl !== 1 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL ovf_counts: got words=%0d lasts=%0d left=%0d, required 8 1 0", words_seen - bw, lasts_seen - bl, exp_q.size());
      end
      @(posedge clk); #1;
      pulse_start(0, 0);
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear_on_start: got %b, required 0", overflow);
      end
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_abort();
      int bw, bl, bd;
      bw = words_seen;
      bl = lasts_seen;
      bd = done_cnt;
      out_ready = 1'b1;
      pulse_start(4, 0);
      adc_sample(0, 1'b1, 1'b0, NCH, 4);
      adc_sample(1, 1'b1, 1'b0, 1, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({out_valid, out_last, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL abort_outputs: got valid/last/busy=%b, required 000", {out_valid, out_last, busy});
      end
      repeat (10) @(negedge clk);
      n_checks++;
      if (words_seen - bw !== 5 || lasts_seen - bl !== 0 || done_cnt - bd !== 0 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL abort_counts: got words=%0d lasts=%0d dones=%0d left=%0d, required 5 0 0 0",
                  words_seen - bw, lasts_seen - bl, done_cnt - bd, exp_q.size());
      end
      @(posedge clk); #1;
      bw = words_seen;
      pulse_start(0, 0);
      n_checks++;
      if ({done, busy} !== 2'b11) begin
         n_fail++;
         $display("FAIL zero_len_done: got done/busy=%b, required 11", {done, busy});
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({done, busy} !== 2'b00 || words_seen - bw !== 0) begin
         n_fail++;
         $display("FAIL zero_len_after: got done/busy=%b words=%0d, required 00 0", {done, busy}, words_seen - bw);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int bw, bl;
      bit ok;
      out_ready = 1'b1;
      pulse_start(2, 0);
      adc_sample(0, 1'b1, 1'b0, NCH, 1);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_i, out_q, out_ch, out_valid, out_last, busy, done, overflow} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got %h, required 0", {out_i, out_q, out_ch, out_valid, out_last, busy, done, overflow});
      end
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bw = words_seen;
      bl = lasts_seen;
      pulse_start(1, 0);
      adc_sample(7, 1'b1, 1'b1, NCH, 1);
      wait_done(30, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL post_reset_done_timeout: got no done, required done within 30 cycles");
      end
      @(negedge clk);
      n_checks++;
      if (words_seen - bw !== 4 || lasts_seen - bl !== 1 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL post_reset_counts: got words=%0d lasts=%0d left=%0d, required 4 1 0", words_seen - bw, lasts_seen - bl, exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      cfg_len   = '0;
      cfg_decim = '0;
      start     = 1'b0;
      abort     = 1'b0;
      adc_i     = '0;
      adc_q     = '0;
      adc_valid = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_basic();
      test_decimation();
      test_backpressure();
      test_overflow();
      test_abort();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by 200000 ns, required completion");
      $fatal(1);
   end

endmodule
